// File: rtl/t06_tone_pkg.sv
// Shared width, state type and duty clip helper for the tone generator.
package t06_tone_pkg;

    localparam int TONE_W = 19;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tone_state_e;

    function automatic logic [TONE_W-1:0] duty_clip(input logic [TONE_W-1:0] max_v,
                                                    input logic [TONE_W-1:0] ratio_v);
        return (ratio_v < max_v) ? ratio_v : max_v;
    endfunction

endpackage

// File: rtl/t06_tone_counter.sv
// Period counter: counts 0..max-1 while inc is high, flags the terminal count on wrap.
module t06_tone_counter
    import t06_tone_pkg::*;
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              clr,
    input  logic              inc,
    input  logic [TONE_W-1:0] max,
    output logic [TONE_W-1:0] cnt,
    output logic              wrap
);

    logic [TONE_W-1:0] cnt_q;
    logic [TONE_W-1:0] cnt_d;

    // max is never 0 while inc is high, so max-1 cannot underflow in use
    assign wrap = (cnt_q == (max - TONE_W'(1)));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + TONE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/t06_tone_gen.sv
// Square-wave tone generator with period/high-time shadowed at each period boundary.
// Optional T06_TONE_VOLUME_EN adds a 2-bit volume input that right-shifts the high time.
//
// state | meaning
// IDLE  | counter held at 0, pwm_out low, waiting for en with a non-rest note
// RUN   | counting a period; shadows reload (or drain to IDLE) only at wrap
module t06_tone_gen
    import t06_tone_pkg::*;
(
    input  logic              clk,
    input  logic              nRst,
    input  logic              en,
    input  logic [TONE_W-1:0] max_in,
    input  logic [TONE_W-1:0] ratio_lookup,
`ifdef T06_TONE_VOLUME_EN
    input  logic [1:0]        volume,
`endif
    output logic              pwm_out,
    output logic              period_done,
    output logic              busy
);

    tone_state_e       state_q, state_d;
    logic [TONE_W-1:0] max_q, max_d;
    logic [TONE_W-1:0] duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [TONE_W-1:0] cnt;
    logic              wrap;
    logic              load_ok;
    logic [TONE_W-1:0] new_duty;

    assign load_ok = en && (max_in != '0) && (ratio_lookup != '0);

`ifdef T06_TONE_VOLUME_EN
    assign new_duty = duty_clip(max_in, ratio_lookup) >> volume;
`else
    assign new_duty = duty_clip(max_in, ratio_lookup);
`endif

    t06_tone_counter u_counter (
        .clk  (clk),
        .nRst (nRst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .max  (max_q),
        .cnt  (cnt),
        .wrap (wrap)
    );

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        duty_d  = duty_q;
        pwm_d   = 1'b0;
        done_d  = 1'b0;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    state_d = RUN;
                    max_d   = max_in;
                    duty_d  = new_duty;
                end
            end
            RUN: begin
                cnt_clr = 1'b0;
                cnt_inc = 1'b1;
                pwm_d   = (cnt < duty_q);
                if (wrap) begin
                    done_d = 1'b1;
                    if (load_ok) begin
                        max_d  = max_in;
                        duty_d = new_duty;
                    end else begin
                        // drain: the period has completed, drop straight to silence
                        state_d = IDLE;
                        pwm_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            max_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = done_q;
    assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_t06_tone_gen.sv
// Randomized and directed bench for t06_tone_gen against a per-period playback model.
module tb_t06_tone_gen;

    logic        clk = 1'b0;
    logic        nRst;
    logic        en;
    logic [18:0] max_in;
    logic [18:0] ratio_lookup;
`ifdef T06_TONE_VOLUME_EN
    logic [1:0]  volume;
`endif
    logic        pwm_out;
    logic        period_done;
    logic        busy;

    always #5 clk = ~clk;

    t06_tone_gen dut (
        .clk          (clk),
        .nRst         (nRst),
        .en           (en),
        .max_in       (max_in),
        .ratio_lookup (ratio_lookup),
`ifdef T06_TONE_VOLUME_EN
        .volume       (volume),
`endif
        .pwm_out      (pwm_out),
        .period_done  (period_done),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    // model: playing flag, position within the note, note length and high time
    bit playing = 0;
    int pos = 0;
    int per = 0;
    int hi  = 0;
    bit e_pwm = 0, e_pd = 0;

    int cnt_pwm = 0, cnt_pd = 0, cnt_busy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int note_high(input int p, input int r);
        int h;
        h = (r >= p) ? p : r;
`ifdef T06_TONE_VOLUME_EN
        h = h >> volume;
`endif
        return h;
    endfunction

    task automatic model_step();
        bit note_ok;
        bit was_high;
        note_ok = en && (max_in != 0) && (ratio_lookup != 0);
        if (!nRst) begin
            playing = 0; pos = 0; e_pwm = 0; e_pd = 0;
        end else if (!playing) begin
            e_pwm = 0; e_pd = 0;
            if (note_ok) begin
                playing = 1; per = int'(max_in); hi = note_high(int'(max_in), int'(ratio_lookup)); pos = 0;
            end
        end else begin
            was_high = (pos < hi);
            e_pd  = (pos == per - 1);
            e_pwm = was_high;
            if (e_pd) begin
                pos = 0;
                if (note_ok) begin
                    per = int'(max_in); hi = note_high(int'(max_in), int'(ratio_lookup));
                end else begin
                    playing = 0; e_pwm = 0;
                end
            end else begin
                pos++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("pwm_out", {31'd0, pwm_out}, {31'd0, e_pwm});
        check("period_done", {31'd0, period_done}, {31'd0, e_pd});
        check("busy", {31'd0, busy}, {31'd0, playing});
        cnt_pwm  += int'(pwm_out);
        cnt_pd   += int'(period_done);
        cnt_busy += int'(busy);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        cnt_pwm = 0; cnt_pd = 0; cnt_busy = 0;
    endtask

    task automatic wait_pos(input int target);
        int guard;
        guard = 0;
        while (!(playing && pos == target) && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) check("wait_pos_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_note(input bit e, input int m, input int r);
        en = e; max_in = 19'(m); ratio_lookup = 19'(r);
    endtask

    initial begin
        nRst = 1'b0;
        set_note(0, 0, 0);
`ifdef T06_TONE_VOLUME_EN
        volume = 2'd0;
`endif
        #1;
        run(3);
        nRst = 1'b1;
        run(3);

        // steady 10/4 tone
        set_note(1, 10, 4);
        run(25);
        clear_counts();
        run(100);
        check("steady_pwm_high", cnt_pwm, 32'd40);
        check("steady_pd_count", cnt_pd, 32'd10);
        check("steady_busy", cnt_busy, 32'd100);

        // mid-period note change takes effect at next boundary
        wait_pos(2);
        set_note(1, 6, 3);
        run(30);

        // drain on en drop
        set_note(1, 10, 4);
        run(20);
        wait_pos(5);
        en = 1'b0;
        run(15);
        check("drain_idle", {31'd0, busy}, 32'd0);

        // rest note never starts
        set_note(1, 0, 4);
        clear_counts();
        run(50);
        check("rest_pd", cnt_pd, 32'd0);
        check("rest_busy", cnt_busy, 32'd0);
        check("rest_pwm", cnt_pwm, 32'd0);

        // oversized ratio: constant high
        set_note(1, 8, 170402);
        run(10);
        clear_counts();
        run(40);
        check("full_duty_pwm", cnt_pwm, 32'd40);

        // period of one: period_done held
        set_note(1, 1, 1);
        run(12);
        clear_counts();
        run(10);
        check("max1_pd", cnt_pd, 32'd10);

        // reset mid-period, then restart
        set_note(1, 10, 4);
        run(20);
        wait_pos(3);
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
        run(30);

        // randomized notes, enables and occasional resets
        for (int s = 0; s < 60; s++) begin
            set_note($urandom_range(3, 0) != 0, $urandom_range(12, 0), $urandom_range(14, 0));
`ifdef T06_TONE_VOLUME_EN
            volume = 2'($urandom_range(3, 0));
`endif
            if ($urandom_range(19, 0) == 0) begin
                nRst = 1'b0;
                tick();
                nRst = 1'b1;
            end
            run($urandom_range(25, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t06_tone_gen.md
T06_TONE_GEN -- requirements
Module: t06_tone_gen

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock) and nRst (input, 1, reset); one clock; reset is synchronous and active-low.
REQ-002 SHALL have port en (input, 1): tone enable from the game control.
REQ-003 SHALL have port max_in (input, 19): period length in clk cycles from the note lookup stage; 0 = rest.
REQ-004 SHALL have port ratio_lookup (input, 19): high-time in clk cycles from the note lookup stage; 0 = rest.
REQ-005 SHALL have port pwm_out (output, 1): registered square-wave speaker drive.
REQ-006 SHALL have port period_done (output, 1): one-cycle pulse at each period boundary.
REQ-007 SHALL have port busy (output, 1): high while in RUN.

Function
REQ-008 SHALL implement FSM states IDLE and RUN, a 19-bit counter cnt, and shadow registers max_q and duty_q.
REQ-009 In IDLE: cnt=0 and pwm_out=0; if en=1, max_in!=0 and ratio_lookup!=0, SHALL load max_q=max_in and duty_q=min(ratio_lookup, max_in), then go to RUN.
REQ-010 In RUN: cnt SHALL increment each cycle; when cnt==max_q-1, cnt SHALL wrap to 0 on the next edge.
REQ-011 In RUN: pwm_out SHALL be registered each cycle as (cnt < duty_q), lagging cnt by one cycle.
REQ-012 Latency: en rising in IDLE at edge N gives busy=1 at N+1 and pwm_out=1 at N+2.
REQ-013 At wrap, period_done SHALL pulse for one cycle, registered with the wrap edge.
REQ-014 At wrap: max_q and duty_q SHALL reload from the inputs; input changes mid-period SHALL have no effect until the next wrap.
REQ-015 At wrap: if en=0, max_in==0 or ratio_lookup==0, the FSM SHALL go to IDLE instead (drain rule).
REQ-016 en deassertion mid-period SHALL NOT truncate the current period; the period completes, then the block goes idle.
REQ-017 ratio_lookup >= max_in SHALL give duty_q=max_q, i.e. pwm_out constantly high while in RUN.
REQ-018 max_q==1 SHALL wrap every cycle, with period_done held high continuously.
REQ-019 Arithmetic: cnt SHALL be unsigned 19-bit; max_q-1 SHALL never underflow because max_q!=0 in RUN.

Reset
REQ-020 With nRst=0 at a clock edge, the block SHALL take state=IDLE, cnt=0, max_q=0, duty_q=0, pwm_out=0, period_done=0, busy=0.
REQ-021 Reset mid-period SHALL abort immediately, with no drain and no period_done pulse.

Configuration
REQ-022 Macro T06_TONE_VOLUME_EN defined SHALL add input volume (2 bits).
REQ-023 With the macro defined, effective duty SHALL be min(ratio_lookup, max_in) >> volume, applied at load; if the result is 0, the block stays in RUN with pwm_out=0.
REQ-024 Without the macro, the volume port SHALL be absent and the behaviour SHALL be exactly REQ-009..REQ-019.

Structure
REQ-025 Package t06_tone_pkg SHALL hold the constant TONE_W=19 and the state enum {IDLE, RUN}.
REQ-026 The period counter with its wrap detect SHALL be sub-module t06_tone_counter (inputs clr, inc, max; outputs cnt, wrap); the FSM, shadow registers and pwm register stay in t06_tone_gen.

Verification
REQ-027 max_in=10, ratio_lookup=4, en=1 -> pwm_out high 4 cycles then low 6, repeating; period_done pulses every 10 cycles; busy=1.
REQ-028 Running 10/4, switch inputs to 6/3 at cnt=2 -> current period stays 10/4; the next period is 6/3.
REQ-029 Running 10/4, drop en at cnt=5 -> period completes; period_done pulses; busy=0 and pwm_out=0 after the wrap.
REQ-030 en=1 with max_in=0 -> FSM stays IDLE, pwm_out=0, period_done=0 for 50 cycles.
REQ-031 max_in=8, ratio_lookup=170402 -> pwm_out constantly 1 in RUN; max_in=1 -> period_done stays high.
REQ-032 nRst=0 at cnt=3 of a 10/4 period -> all outputs 0 next cycle; with en=1 after release, restart from cnt=0 as in REQ-012.
